// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: next-PC selects,
// fault codes and the run/fault state.
package pc_seq_pkg;

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UDF  = 2'b10
  } fault_code_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Controller <-> sequencer bus: control inputs in, PC and stack status out.
interface pc_sequencer_if #(
  parameter int PC_W   = 12,
  parameter int DISP_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              en;
  logic [1:0]        next_sel;
  logic [PC_W-1:0]   target;
  logic [DISP_W-1:0] disp;
  logic              call;
  logic              ret;
  logic [PC_W-1:0]   pc;
  logic [CNT_W-1:0]  sp_count;
  logic              stack_empty;
  logic              stack_full;
  logic              fault;
  logic [1:0]        fault_code;

  modport master (
    output en, next_sel, target, disp, call, ret,
    input  pc, sp_count, stack_empty, stack_full, fault, fault_code
  );

  modport slave (
    input  en, next_sel, target, disp, call, ret,
    output pc, sp_count, stack_empty, stack_full, fault, fault_code
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses with occupancy count; push/pop/replace act on the
// rising edge, top reflects the pre-edge contents.
module return_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] topIdx;
  logic [IDX_W-1:0] pushIdx;

  assign topIdx  = IDX_W'(cnt - 1'b1);
  assign pushIdx = IDX_W'(cnt);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign top     = mem[topIdx];

  always_ff @(posedge clk) begin
    if (!rst)                  cnt <= '0;
    else if (push && !full)    cnt <= cnt + 1'b1;
    else if (pop && !empty)    cnt <= cnt - 1'b1;
  end

  // Entries carry no reset; only the count defines what is valid.
  always_ff @(posedge clk) begin
    if (rst && push && !full)          mem[pushIdx] <= din;
    else if (rst && replace && !empty) mem[topIdx]  <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with relative/absolute next-PC select, return stack and a
// sticky overflow/underflow fault that freezes all state until reset.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              DISP_W   = 8,
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  seq_state_e        state, stateNext;
  fault_code_e       code, codeNext;
  logic [PC_W-1:0]   pc, pcNext;
  logic [PC_W-1:0]   inc, br, seqNext;
  logic [PC_W-1:0]   top;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              active, doCall, doRet, doSwap, ovf, udf;

  assign inc = pc + 1'b1;
  assign br  = inc + PC_W'($signed(bus.disp));

  always_comb begin
    seqNext = inc;
    case (bus.next_sel)
      SEL_BR:  seqNext = br;
      SEL_JMP: seqNext = bus.target;
      default: seqNext = inc;
    endcase
  end

  assign active = bus.en && (state == S_RUN);
  assign doCall = active && bus.call && !bus.ret && !full;
  assign doRet  = active && !bus.call && bus.ret && !empty;
  assign doSwap = active && bus.call && bus.ret && !empty;
  assign ovf    = active && bus.call && !bus.ret && full;
  assign udf    = active && bus.ret && empty;

  return_stack #(.W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (doCall),
    .pop     (doRet),
    .replace (doSwap),
    .din     (inc),
    .top     (top),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Returns and swaps both take the old top; faults leave pc where it is.
  always_comb begin
    pcNext = pc;
    if (doRet || doSwap)            pcNext = top;
    else if (active && !ovf && !udf) pcNext = seqNext;
  end

  always_comb begin
    stateNext = state;
    codeNext  = code;
    if (state == S_RUN) begin
      if (ovf) begin
        stateNext = S_FAULT;
        codeNext  = FLT_OVF;
      end else if (udf) begin
        stateNext = S_FAULT;
        codeNext  = FLT_UDF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      state <= S_RUN;
      code  <= FLT_NONE;
    end else begin
      pc    <= pcNext;
      state <= stateNext;
      code  <= codeNext;
    end
  end

  assign bus.pc          = pc;
  assign bus.sp_count    = count;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.fault       = (state == S_FAULT);
  assign bus.fault_code  = code;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes expected state
// per driven cycle, popped and compared one cycle later.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(12), .DISP_W(8), .DEPTH(8)) bus ();

  pc_sequencer #(.PC_W(12), .DISP_W(8), .DEPTH(8), .RESET_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        flt;
    logic [1:0]  code;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails  = 0;

  logic [11:0] mPc;
  logic [11:0] mStk[$];
  logic        mFault;
  logic [1:0]  mCode;

  // One clock: update model, push expectation, drive, edge, pop and compare.
  task automatic step(input logic rv, input logic e, input logic [1:0] sel,
                      input logic [11:0] tgt, input logic [7:0] dsp,
                      input logic c, input logic r);
    logic [11:0] inc, br, seq, t;
    exp_t ex, got;
    if (!rv) begin
      mPc = 12'h000; mStk.delete(); mFault = 1'b0; mCode = 2'b00;
    end else if (e && !mFault) begin
      inc = mPc + 12'd1;
      br  = inc + {{4{dsp[7]}}, dsp};
      seq = (sel == 2'b01) ? br : (sel == 2'b10) ? tgt : inc;
      if (c && !r) begin
        if (mStk.size() == 8) begin mFault = 1'b1; mCode = 2'b01; end
        else begin mStk.push_back(inc); mPc = seq; end
      end else if (r) begin
        if (mStk.size() == 0) begin mFault = 1'b1; mCode = 2'b10; end
        else if (c) begin t = mStk[$]; mStk[$] = inc; mPc = t; end
        else mPc = mStk.pop_back();
      end else mPc = seq;
    end
    ex.pc = mPc; ex.sp = 4'(mStk.size()); ex.flt = mFault; ex.code = mCode;
    sbq.push_back(ex);
    rst = rv; bus.en = e; bus.next_sel = sel; bus.target = tgt;
    bus.disp = dsp; bus.call = c; bus.ret = r;
    @(posedge clk); #1;
    got = sbq.pop_front();
    checks++;
    if (bus.pc !== got.pc || bus.sp_count !== got.sp || bus.fault !== got.flt ||
        bus.fault_code !== got.code || bus.stack_empty !== (got.sp == 0) ||
        bus.stack_full !== (got.sp == 8)) begin
      fails++;
      $display("FAIL scoreboard t=%0t: pc=%h sp=%0d e=%b f=%b flt=%b code=%b, need pc=%h sp=%0d flt=%b code=%b",
               $time, bus.pc, bus.sp_count, bus.stack_empty, bus.stack_full, bus.fault,
               bus.fault_code, got.pc, got.sp, got.flt, got.code);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'b00, 12'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 2'b10, 12'h5A5, 8'h0, 1'b1, 1'b1);
    chk("reset_pc", 16'(bus.pc), 16'h000);
    chk("reset_empty", 16'(bus.stack_empty), 16'h1);
    chk("reset_fault", 16'({bus.fault, bus.fault_code}), 16'h0);
  endtask

  task automatic test_increment();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b0, 1'b0);
    chk("inc_pc4", 16'(bus.pc), 16'h004);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'b10, 12'h123, 8'h0, 1'b1, 1'b0);
    chk("hold_pc4", 16'(bus.pc), 16'h004);
    chk("hold_sp", 16'(bus.sp_count), 16'h0);
  endtask

  task automatic test_branch();
    step(1'b1, 1'b1, 2'b10, 12'h010, 8'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b01, 12'h0, 8'hF0, 1'b0, 1'b0);
    chk("branch_back", 16'(bus.pc), 16'h001);
    step(1'b1, 1'b1, 2'b11, 12'h0, 8'h10, 1'b0, 1'b0);
    chk("sel11_inc", 16'(bus.pc), 16'h002);
    step(1'b1, 1'b1, 2'b10, 12'hFFF, 8'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b0, 1'b0);
    chk("wrap_pc", 16'(bus.pc), 16'h000);
    chk("wrap_nofault", 16'(bus.fault), 16'h0);
  endtask

  task automatic test_call_ret();
    step(1'b1, 1'b1, 2'b10, 12'h020, 8'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b10, 12'h300, 8'h0, 1'b1, 1'b0);
    chk("call_pc", 16'(bus.pc), 16'h300);
    chk("call_sp", 16'(bus.sp_count), 16'h1);
    step(1'b1, 1'b1, 2'b10, 12'h7FF, 8'h0, 1'b0, 1'b1);
    chk("ret_pc", 16'(bus.pc), 16'h021);
    chk("ret_empty", 16'(bus.stack_empty), 16'h1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b1, 1'b0);
    chk("ovf_full", 16'(bus.stack_full), 16'h1);
    chk("ovf_pc8", 16'(bus.pc), 16'h008);
    step(1'b1, 1'b1, 2'b10, 12'h400, 8'h0, 1'b1, 1'b0);
    chk("ovf_fault", 16'({bus.fault, bus.fault_code}), 16'h5);
    chk("ovf_pc_hold", 16'(bus.pc), 16'h008);
    step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2'b10, 12'h111, 8'h0, 1'b0, 1'b0);
    chk("ovf_frozen_pc", 16'(bus.pc), 16'h008);
    chk("ovf_frozen_sp", 16'(bus.sp_count), 16'h8);
    do_reset();
    chk("ovf_cleared", 16'({bus.fault, bus.fault_code, 4'(bus.sp_count)}), 16'h0);
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b0, 1'b1);
    chk("udf_code", 16'(bus.fault_code), 16'h2);
    chk("udf_pc", 16'(bus.pc), 16'h000);
    step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b1, 1'b0);
    chk("udf_first_kept", 16'(bus.fault_code), 16'h2);
    do_reset();
    step(1'b1, 1'b1, 2'b10, 12'h300, 8'h0, 1'b1, 1'b1);
    chk("swap_empty_udf", 16'({bus.fault, bus.fault_code}), 16'h6);
    do_reset();
  endtask

  task automatic test_swap();
    step(1'b1, 1'b1, 2'b10, 12'h054, 8'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b10, 12'h100, 8'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b10, 12'h777, 8'h0, 1'b1, 1'b1);
    chk("swap_pc", 16'(bus.pc), 16'h055);
    chk("swap_sp", 16'(bus.sp_count), 16'h1);
    step(1'b1, 1'b1, 2'b00, 12'h0, 8'h0, 1'b0, 1'b1);
    chk("swap_ret", 16'(bus.pc), 16'h101);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 12'($urandom), 8'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    rst = 1'b0; bus.en = 1'b0; bus.next_sel = 2'b00; bus.target = '0;
    bus.disp = '0; bus.call = 1'b0; bus.ret = 1'b0;
    mPc = '0; mFault = 1'b0; mCode = 2'b00;
    @(negedge clk);
    test_reset();
    test_increment();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_swap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer; it is the successor to the fixed 12-bit PC/adder/stack/next-PC mux cluster in the single-cycle CPU datapath.
- Generalises PC width, displacement width and return-stack depth.
- Adds stack occupancy flags, overflow/underflow detection with a sticky halting fault, and a defined call+return (swap) mode.
- Sits between the controller (select/call/ret/enable) and the instruction memory (address = pc).

Parameters:
PC_W, 12, program counter and return-address width in bits
DISP_W, 8, signed branch displacement width (1 <= DISP_W <= PC_W)
DEPTH, 8, return-stack entries (>= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
en  input  1  advance enable (pcEn equivalent); 0 = hold all state
next_sel  input  2  00 increment, 01 relative branch, 10 absolute jump, 11 treated as 00
target  input  PC_W  absolute jump address
disp  input  DISP_W  signed displacement for relative branch
call  input  1  push return address (pc+1) and take next_sel target
ret  input  1  load pc from top of stack and pop
pc  output  PC_W  current program counter
sp_count  output  $clog2(DEPTH+1)  entries currently on stack
stack_empty  output  1  sp_count == 0
stack_full  output  1  sp_count == DEPTH
fault  output  1  sticky fault; halts sequencer until reset
fault_code  output  2  00 none, 01 overflow, 10 underflow

Behaviour:
- Reset (rst=0 at edge, regardless of en): pc=RESET_PC, sp_count=0, stack_empty=1, stack_full=0, fault=0, fault_code=00. Stack contents are don't-care.
- Arithmetic:
  - inc = pc+1 mod 2^PC_W.
  - br = inc + sign_extend(disp) mod 2^PC_W.
  - seq_next = inc / br / target / inc for next_sel 00/01/10/11.
  - Wrap-around is silent; no fault.
- Edge with en=0 or fault=1: all state holds; call and ret are ignored.
- Edge with en=1, fault=0 (all changes take effect next cycle; pc output is registered, latency 1):
  - call=0, ret=0: pc <= seq_next.
  - call=1, ret=0, not full: stack[sp] <= inc; sp_count+1; pc <= seq_next.
  - call=1, ret=0, full: overflow. pc, stack and sp hold; fault <= 1, fault_code <= 01.
  - call=0, ret=1, not empty: pc <= top; sp_count-1.
  - call=0, ret=1, empty: underflow. pc holds; fault <= 1, fault_code <= 10.
  - call=1, ret=1, not empty (swap/coroutine): pc <= old top; top entry <= inc; sp_count unchanged. next_sel is ignored.
  - call=1, ret=1, empty: underflow, same as above.
- Flags are combinational from sp_count.
- fault_code records only the first fault. It stays until reset.
- Reset mid-sequence discards all stack entries; no pending operation survives.
- A read of the top entry on the same edge as a write to it uses the pre-edge value.

Decomposition:
- Package pc_seq_pkg:
  - next_sel encodings SEL_INC, SEL_BR, SEL_JMP.
  - fault codes FLT_NONE, FLT_OVF, FLT_UDF.
- Sub-module return_stack, parametrised by width and depth.
  - Inputs: push, pop, replace, din.
  - Outputs: top, count, full, empty.
  - It contains the register array and pointer; pc_sequencer holds the PC, next-PC arithmetic and fault FSM.

Test Plan:
1. Reset, then en=1, next_sel=00 for 4 cycles -> pc 0,1,2,3,4. Then en=0 for 2 cycles -> pc stays 4.
2. pc=0x010, next_sel=01, disp=0xF0 (-16) -> pc=0x001. pc=0xFFF, next_sel=00 -> pc=0x000 (wrap, no fault).
3. pc=0x020: call=1, next_sel=10, target=0x300 -> pc=0x300, sp_count=1, stack_empty=0. Next cycle ret=1 -> pc=0x021, sp_count=0.
4. Eight nested calls -> stack_full=1. Ninth call -> fault=1, fault_code=01, pc unchanged. Further en/ret have no effect until rst=0.
5. From reset, ret=1 -> fault=1, fault_code=10, pc=RESET_PC.
6. Stack top=0x055, pc=0x100: call=1 and ret=1 together -> pc=0x055, top=0x101, sp_count unchanged. Then ret=1 -> pc=0x101.
